// File: rtl/fb_pixel_writer_if.sv
// Frame-buffer memory write bus: request/address/data held by the master
// until the slave acknowledges.
interface fb_pixel_writer_if;
  logic        memReq;
  logic [16:0] memAddr;
  logic [31:0] memWData;
  logic        memAck;

  modport master (
    output memReq,
    output memAddr,
    output memWData,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memAddr,
    input  memWData,
    output memAck
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: collects one frame of pixels from an upstream source,
// packs them into 32-bit words, buffers them in a small FIFO and writes them
// to sequential frame-buffer addresses starting at BASE_ADDR.
// Optional feature: define FB_RGB565_EN to convert pixels to RGB565 and pack
// two per word (first pixel in [15:0]); otherwise one RGB888 pixel per word.
module fb_pixel_writer #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FRAME_PIXELS = 130560
) (
  input  logic              clk_12,
  input  logic              rst,
  input  logic              startFrame,
  output logic              newFrame,
  input  logic              srcBsy,
  input  logic              pixelValid,
  input  logic [23:0]       pixelColor,
  fb_pixel_writer_if.master mem,
  output logic              bsy,
  output logic              frameDone,
  output logic              overflow
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [16:0] BASE     = 17'(BASE_ADDR);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_SRC,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] pix_cnt;
  logic        start_go;
  logic        in_window;
  logic        frame_full;
  logic        accept;

  logic        push;
  logic [31:0] push_data;
  logic        pack_empty;
  logic        push_ok;
  logic        drop;
  logic        pop;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full;

  logic          req_q;
  logic [16:0]   addr_q;
  logic [31:0]   wdata_q;

  assign start_go   = (state == IDLE) && startFrame;
  assign in_window  = (state == WAIT_SRC) || (state == STREAM);
  assign frame_full = (32'(pix_cnt) >= FRAME_PIXELS);
  assign accept     = pixelValid && in_window && !frame_full;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  // The output stage reloads in the same cycle it is acknowledged, so the
  // bus sustains one word per cycle.
  assign pop        = !fifo_empty && (!req_q || mem.memAck);
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  assign mem.memReq   = req_q;
  assign mem.memAddr  = addr_q;
  assign mem.memWData = wdata_q;

  // State register
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    newFrame  = 1'b0;
    frameDone = 1'b0;
    bsy       = 1'b1;
    unique case (state)
      IDLE: begin
        bsy = 1'b0;
        if (startFrame) begin
          state_nxt = REQUEST;
        end
      end
      REQUEST: begin
        newFrame  = 1'b1;
        state_nxt = WAIT_SRC;
      end
      WAIT_SRC: begin
        if (srcBsy) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (!srcBsy || frame_full) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // Leave once the last word is being (or has been) accepted and
        // nothing remains in the packer or FIFO.
        if (pack_empty && fifo_empty && (!req_q || mem.memAck)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        frameDone = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accepted-pixel counter, cleared at the start of each frame
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
    end else if (start_go) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= pix_cnt + 17'd1;
    end
  end

`ifdef FB_RGB565_EN
  logic [15:0] half_q;
  logic        half_vld;

  function automatic logic [15:0] to_565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  assign pack_empty = !half_vld;

  // Word assembly: second pixel of a pair, or the odd leftover during FLUSH
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      if (half_vld) begin
        push      = 1'b1;
        push_data = {to_565(pixelColor), half_q};
      end
    end else if ((state == FLUSH) && half_vld) begin
      push      = 1'b1;
      push_data = {16'h0000, half_q};
    end
  end

  // Holding register for the first pixel of each pair
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      half_q   <= '0;
      half_vld <= 1'b0;
    end else if (start_go) begin
      half_q   <= '0;
      half_vld <= 1'b0;
    end else if (accept) begin
      if (half_vld) begin
        half_vld <= 1'b0;
      end else begin
        half_q   <= to_565(pixelColor);
        half_vld <= 1'b1;
      end
    end else if ((state == FLUSH) && half_vld) begin
      half_vld <= 1'b0;
    end
  end
`else
  assign pack_empty = 1'b1;

  // One zero-extended RGB888 pixel per word
  always_comb begin
    push      = accept;
    push_data = {8'h00, pixelColor};
  end
`endif

  // FIFO storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk_12) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set when a word is dropped, cleared on frame start
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (start_go) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Bus output stage: request and data held until acknowledged
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      wdata_q <= '0;
    end else if (pop) begin
      req_q   <= 1'b1;
      wdata_q <= fifo_mem[rd_ptr];
    end else if (mem.memAck) begin
      req_q   <= 1'b0;
    end
  end

  // Write address: reloaded at frame start, advanced per accepted word
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      addr_q <= BASE;
    end else if (start_go) begin
      addr_q <= BASE;
    end else if (req_q && mem.memAck) begin
      addr_q <= addr_q + 17'd1;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed frame table, stall/overflow and reset
// sequences, and random frames checked against a packing model.
module tb_fb_pixel_writer;
  localparam int unsigned BASE  = 'h1FFFE;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 13;

  logic        clk_12 = 1'b0;
  logic        rst = 1'b0;
  logic        startFrame = 1'b0;
  logic        srcBsy = 1'b0;
  logic        pixelValid = 1'b0;
  logic [23:0] pixelColor = '0;
  logic        newFrame, bsy, frameDone, overflow;

  fb_pixel_writer_if mem ();

  fb_pixel_writer #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .FRAME_PIXELS(FRAME)
  ) dut (
    .clk_12    (clk_12),
    .rst       (rst),
    .startFrame(startFrame),
    .newFrame  (newFrame),
    .srcBsy    (srcBsy),
    .pixelValid(pixelValid),
    .pixelColor(pixelColor),
    .mem       (mem),
    .bsy       (bsy),
    .frameDone (frameDone),
    .overflow  (overflow)
  );

  always #5 clk_12 = ~clk_12;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12);
    #1;
  endtask

  // Acknowledge driver: 0 tied high, 1 held low, 2 random (never >2 lows)
  int ack_mode = 1;
  int low_run  = 0;
  always @(posedge clk_12) begin
    #1;
    case (ack_mode)
      0: mem.memAck = 1'b1;
      1: mem.memAck = 1'b0;
      default: begin
        if (low_run >= 2) mem.memAck = 1'b1;
        else mem.memAck = 1'($urandom_range(1, 0));
        low_run = mem.memAck ? 0 : low_run + 1;
      end
    endcase
  end

  // Bus monitor, sampled on the falling edge
  logic [16:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          nf_cnt = 0;
  int          fd_cnt = 0;
  int          stab_err = 0;
  logic        hold = 1'b0;
  logic [16:0] hold_addr;
  logic [31:0] hold_data;
  always @(negedge clk_12) begin
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold && (!mem.memReq || mem.memAddr !== hold_addr || mem.memWData !== hold_data))
        stab_err++;
      if (newFrame) nf_cnt++;
      if (frameDone) fd_cnt++;
      if (mem.memReq && mem.memAck) begin
        wr_addr_q.push_back(mem.memAddr);
        wr_data_q.push_back(mem.memWData);
      end
      hold      = mem.memReq && !mem.memAck;
      hold_addr = mem.memAddr;
      hold_data = mem.memWData;
    end
  end

  // Reference model: expected words from the driven pixel list
  logic [23:0] drv_q [$];
  logic [31:0] exp_q [$];

  function automatic logic [15:0] rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  task automatic build_expected();
    int m;
    exp_q.delete();
    m = (drv_q.size() < FRAME) ? drv_q.size() : FRAME;
`ifdef FB_RGB565_EN
    for (int i = 0; i < m; i += 2)
      exp_q.push_back({(i + 1 < m) ? rgb565(drv_q[i+1]) : 16'h0000, rgb565(drv_q[i])});
`else
    for (int i = 0; i < m; i++)
      exp_q.push_back({8'h00, drv_q[i]});
`endif
  endtask

  // Runs one frame: start, stream drv_q with random gaps, wait for frameDone
  task automatic do_frame(input string tag, input int gmin, input int gmax,
                          input bit inject, input bit stall);
    int waited;
    wr_addr_q.delete();
    wr_data_q.delete();
    nf_cnt = 0; fd_cnt = 0; stab_err = 0;
    startFrame = 1'b1;
    tick();
    startFrame = 1'b0;
    waited = 0;
    while (nf_cnt == 0 && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, "_newframe_seen"}, 32'(nf_cnt > 0), 1);
    check({tag, "_ovf_cleared"}, overflow, 0);
    srcBsy = 1'b1;
    for (int i = 0; i < drv_q.size(); i++) begin
      pixelValid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) tick();
      pixelValid = 1'b1;
      pixelColor = drv_q[i];
      startFrame = inject && (i == 2);
      tick();
    end
    pixelValid = 1'b0;
    startFrame = 1'b0;
    srcBsy     = 1'b0;
    if (stall) begin
      repeat (4) tick();
      check({tag, "_ovf_set"}, overflow, 1);
      ack_mode = 0;
    end
    waited = 0;
    while (fd_cnt == 0 && waited < 400) begin
      tick();
      waited++;
    end
    check({tag, "_done_in_time"}, 32'(fd_cnt > 0), 1);
    repeat (4) tick();
    check({tag, "_done_once"}, fd_cnt, 1);
    check({tag, "_newframe_once"}, nf_cnt, 1);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_idle"}, bsy, 0);
    check({tag, "_ovf_end"}, overflow, 32'(stall));
  endtask

  task automatic compare_words(input string tag, input bit exact);
    int m;
    if (exact) check({tag, "_count"}, wr_data_q.size(), exp_q.size());
    else check({tag, "_partial_count"},
               32'(wr_data_q.size() >= 1 && wr_data_q.size() < exp_q.size()), 1);
    m = (wr_data_q.size() < exp_q.size()) ? wr_data_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, wr_addr_q[i], 17'(BASE + 32'(i)));
      check({tag, "_data"}, wr_data_q[i], exp_q[i]);
    end
  endtask

  task automatic rand_frame(input int f);
    int n;
    n = $urandom_range(18, 1);
    drv_q.delete();
    for (int i = 0; i < n; i++) drv_q.push_back(24'($urandom));
    build_expected();
    if (f % 2 == 0) begin
      ack_mode = 0;
      do_frame("rnd_fast", 0, 0, 1'b0, 1'b0);
    end else begin
      ack_mode = 2;
      do_frame("rnd_slow", 2, 4, 1'b0, 1'b0);
    end
    compare_words("rnd", 1'b1);
  endtask

  typedef struct {
    int               n;
    logic [8:0][23:0] pix;
    int               nw;
    logic [8:0][31:0] w;
    bit               inject;
  } vec_t;

  vec_t tbl [3];

  initial begin
    tbl[0].n = 4; tbl[0].inject = 1'b0;
    tbl[0].pix[0] = 24'hFF0000; tbl[0].pix[1] = 24'h00FF00;
    tbl[0].pix[2] = 24'h0000FF; tbl[0].pix[3] = 24'hFFFFFF;
    tbl[1].n = 3; tbl[1].inject = 1'b0;
    for (int i = 0; i < 3; i++) tbl[1].pix[i] = 24'h123456;
    tbl[2].n = 9; tbl[2].inject = 1'b1;
    tbl[2].pix[0] = 24'hFFFFFF; tbl[2].pix[1] = 24'h000000; tbl[2].pix[2] = 24'hFF0000;
    tbl[2].pix[3] = 24'h00FF00; tbl[2].pix[4] = 24'h0000FF; tbl[2].pix[5] = 24'h123456;
    tbl[2].pix[6] = 24'hFFFFFF; tbl[2].pix[7] = 24'hAAAAAA; tbl[2].pix[8] = 24'h555555;
`ifdef FB_RGB565_EN
    tbl[0].nw = 2; tbl[0].w[0] = 32'h07E0F800; tbl[0].w[1] = 32'hFFFF001F;
    tbl[1].nw = 2; tbl[1].w[0] = 32'h11AA11AA; tbl[1].w[1] = 32'h000011AA;
    tbl[2].nw = 5;
    tbl[2].w[0] = 32'h0000FFFF; tbl[2].w[1] = 32'h07E0F800; tbl[2].w[2] = 32'h11AA001F;
    tbl[2].w[3] = 32'hAD55FFFF; tbl[2].w[4] = 32'h000052AA;
`else
    tbl[0].nw = 4;
    tbl[0].w[0] = 32'h00FF0000; tbl[0].w[1] = 32'h0000FF00;
    tbl[0].w[2] = 32'h000000FF; tbl[0].w[3] = 32'h00FFFFFF;
    tbl[1].nw = 3;
    for (int i = 0; i < 3; i++) tbl[1].w[i] = 32'h00123456;
    tbl[2].nw = 9;
    tbl[2].w[0] = 32'h00FFFFFF; tbl[2].w[1] = 32'h00000000; tbl[2].w[2] = 32'h00FF0000;
    tbl[2].w[3] = 32'h0000FF00; tbl[2].w[4] = 32'h000000FF; tbl[2].w[5] = 32'h00123456;
    tbl[2].w[6] = 32'h00FFFFFF; tbl[2].w[7] = 32'h00AAAAAA; tbl[2].w[8] = 32'h00555555;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_memreq", mem.memReq, 0);
    check("rst_memaddr", mem.memAddr, 17'(BASE));
    check("rst_memwdata", mem.memWData, 0);
    check("rst_bsy", bsy, 0);
    check("rst_newframe", newFrame, 0);
    check("rst_framedone", frameDone, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Directed frames with memAck tied high
    for (int r = 0; r < 3; r++) begin
      drv_q.delete();
      for (int i = 0; i < tbl[r].n; i++) drv_q.push_back(tbl[r].pix[i]);
      exp_q.delete();
      for (int i = 0; i < tbl[r].nw; i++) exp_q.push_back(tbl[r].w[i]);
      ack_mode = 0;
      do_frame("vec", 0, 0, tbl[r].inject, 1'b0);
      compare_words("vec", 1'b1);
    end

    // Acknowledge held low while pixels stream continuously
    drv_q.delete();
    for (int i = 0; i < 20; i++) drv_q.push_back(24'($urandom));
    build_expected();
    ack_mode = 1;
    do_frame("ovf", 0, 0, 1'b0, 1'b1);
    compare_words("ovf", 1'b0);

    for (int f = 0; f < 24; f++) rand_frame(f);

    // Reset in the middle of a stalled stream
    ack_mode = 1;
    startFrame = 1'b1;
    tick();
    startFrame = 1'b0;
    repeat (2) tick();
    srcBsy = 1'b1;
    pixelValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pixelColor = 24'($urandom);
      tick();
    end
    check("midrst_pre_memreq", mem.memReq, 1);
    check("midrst_pre_bsy", bsy, 1);
    rst = 1'b0;
    tick();
    check("midrst_memreq", mem.memReq, 0);
    check("midrst_bsy", bsy, 0);
    check("midrst_memaddr", mem.memAddr, 17'(BASE));
    check("midrst_overflow", overflow, 0);
    check("midrst_memwdata", mem.memWData, 0);
    pixelValid = 1'b0;
    srcBsy = 1'b0;
    ack_mode = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rst = 1'b1;
    repeat (20) tick();
    check("midrst_no_write", wr_data_q.size(), 0);
    check("midrst_idle_req", mem.memReq, 0);

    for (int f = 0; f < 4; f++) rand_frame(f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 Parameter BASE_ADDR, default 0: word address of the first frame-buffer word.
REQ-002 Parameter FIFO_DEPTH, default 8: word FIFO depth; power of two, 4 to 32.
REQ-003 Parameter FRAME_PIXELS, default 130560: pixels per frame (480x272).
REQ-004 clk_12  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 startFrame  in  1  one-cycle pulse requesting that one frame be written.
REQ-007 newFrame  out  1  one-cycle pulse to the upstream pixel source to start rendering.
REQ-008 srcBsy  in  1  upstream busy flag.
REQ-009 pixelValid  in  1  pixelColor is valid this cycle; there is no backpressure.
REQ-010 pixelColor  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 memReq  out  1  write request to the frame-buffer memory.
REQ-012 memAddr  out  17  word address.
REQ-013 memWData  out  32  write data.
REQ-014 memAck  in  1  write accepted this cycle.
REQ-015 bsy  out  1  high in every state except IDLE.
REQ-016 frameDone  out  1  one-cycle pulse when the last word is accepted.
REQ-017 overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-018 The state machine SHALL have the states IDLE, REQUEST, WAIT_SRC, STREAM, FLUSH and DONE.
REQ-019 IDLE→REQUEST on startFrame; this transition also clears overflow, the pixel counter and the packer, and loads the address counter with BASE_ADDR.
REQ-020 startFrame outside IDLE SHALL be ignored.
REQ-021 REQUEST lasts exactly one cycle; newFrame is high only in REQUEST; next state is WAIT_SRC.
REQ-022 WAIT_SRC→STREAM on the first cycle srcBsy is high; the block waits indefinitely; pixelValid is accepted in WAIT_SRC.
REQ-023 STREAM→FLUSH when srcBsy is low or the pixel counter reaches FRAME_PIXELS, whichever occurs first.
REQ-024 pixelValid outside WAIT_SRC and STREAM, and any pixels beyond FRAME_PIXELS, SHALL be ignored.
REQ-025 FLUSH pushes any partial packer word, then waits until the FIFO is empty and no request is outstanding; next state is DONE.
REQ-026 DONE lasts one cycle, asserts frameDone, and returns to IDLE.
REQ-027 Memory handshake: memReq, memAddr and memWData SHALL stay stable from assertion until the cycle memAck is sampled high.
REQ-028 memAddr increments by 1 per accepted word, wrapping modulo 2^17.
REQ-029 A new request may be presented the cycle after an ack, giving a throughput of one word per cycle.
REQ-030 memAck while memReq is low SHALL be ignored.
REQ-031 FIFO push and pop in the same cycle SHALL be legal when the FIFO is full or empty: pop-empty is a no-op; push-full with a simultaneous pop succeeds.
REQ-032 A push to a full FIFO with no pop SHALL drop the word, set overflow, and still advance the pixel counter.
REQ-033 Latency: pixel in to memReq high is at most 3 cycles when the FIFO is empty.
REQ-034 The pixel counter is 17 bits, unsigned, and counts accepted pixels.

Reset
REQ-035 Reset SHALL force: state IDLE, FIFO empty, packer empty, counters 0, memAddr BASE_ADDR, and memReq, newFrame, bsy, frameDone, overflow and memWData all 0.
REQ-036 Reset mid-frame SHALL abandon the outstanding request immediately; no partial word is written afterwards.

Configuration
REQ-037 Macro FB_RGB565_EN defined: each pixel is converted to {R[7:3],G[7:2],B[7:3]} and two pixels are packed per word, first pixel in [15:0] and second in [31:16].
REQ-038 With FB_RGB565_EN, an odd final pixel is flushed with [31:16]=0; a frame writes ceil(FRAME_PIXELS/2) words.
REQ-039 Macro FB_RGB565_EN absent: one pixel per word, memWData={8'h00,pixelColor}; a frame writes FRAME_PIXELS words.

Verification
REQ-040 Reset mid-STREAM with memReq high → next cycle memReq=0, bsy=0, memAddr=BASE_ADDR, overflow=0.
REQ-041 startFrame; newFrame pulses 1 cycle; srcBsy high; 4 pixels 0xFF0000,0x00FF00,0x0000FF,0xFFFFFF; srcBsy low; memAck tied high → RGB565: words 0x07E0F800@0, 0xFFFF001F@1; frameDone pulses once; RGB888: 4 words at 0-3.
REQ-042 FRAME_PIXELS=3, RGB565, 3 pixels 0x123456 → words 0x11AA11AA@0, 0x000011AA@1; frameDone.
REQ-043 memAck low for 20 cycles during continuous pixels, FIFO_DEPTH=4 → overflow=1; memAddr/memWData stable while memReq is high; overflow clears on the next accepted startFrame.
REQ-044 startFrame pulsed in STREAM → ignored: no second newFrame, word count unchanged.
REQ-045 Full frame of 130560 pixels with random memAck stalls, RGB565 → exactly 65280 writes at addresses 0..65279, no gaps, overflow=0 if average ack ≥ 1 per 2 cycles.
